// File: rtl/seq_detect_param.sv
// seq_detect_param: parametrised Mealy serial sequence detector.
//
// Detects PATTERN (PAT_LEN bits, MSB received first) on a 1-bit serial
// stream. The match flag is combinational and asserts in the same cycle
// as the final pattern bit. A saturating counter tallies matches.
//
// Parameters:
//   PAT_LEN  pattern length, 2..16
//   PATTERN  pattern bits; bit PAT_LEN-1 first, bit 0 last; upper bits ignored
//   OVERLAP  1 = overlapping matches, 0 = restart from empty after a match
//   CNT_W    match counter width
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   en         din valid this cycle; state and counter hold when low
//   din        serial data bit
//   clr_cnt    synchronous clear of match_cnt and cnt_sat (beats an increment)
//   dout       Mealy match flag
//   match_cnt  saturating match count
//   cnt_sat    sticky saturation flag
module seq_detect_param #(
  parameter int          PAT_LEN = 4,
  parameter logic [15:0] PATTERN = 16'b1010,
  parameter bit          OVERLAP = 1'b1,
  parameter int          CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             din,
  input  logic             clr_cnt,
  output logic             dout,
  output logic [CNT_W-1:0] match_cnt,
  output logic             cnt_sat
);

  if (PAT_LEN < 2 || PAT_LEN > 16) begin : g_bad_len
    $fatal(1, "seq_detect_param: PAT_LEN must be in 2..16");
  end

  localparam int SW = (PAT_LEN >= 2) ? $clog2(PAT_LEN) : 1;
  localparam int NS = 2 ** SW;
  localparam logic [SW-1:0]    LAST    = SW'(PAT_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Length of the longest pattern prefix that is a suffix of
  // (prefix of length s) followed by b, capped below PAT_LEN. For a full
  // match this yields the KMP failure value; for a matching non-final bit
  // it yields s+1.
  function automatic int next_len(int s, bit b);
    int  best;
    int  p;
    bit  ok;
    bit  tc;
    best = 0;
    for (int k = 1; k < PAT_LEN; k++) begin
      if (k <= s + 1) begin
        ok = 1'b1;
        for (int i = 0; i < k; i++) begin
          p  = s + 1 - k + i;
          tc = (p == s) ? b : PATTERN[PAT_LEN-1-p];
          if (tc != PATTERN[PAT_LEN-1-i]) ok = 1'b0;
        end
        if (ok) best = k;
      end
    end
    return best;
  endfunction

  // Transition tables, fixed at elaboration; unreachable codes go to 0.
  logic [SW-1:0] nxt0 [NS];
  logic [SW-1:0] nxt1 [NS];

  for (genvar gs = 0; gs < NS; gs++) begin : g_tbl
    if (gs < PAT_LEN) begin : g_live
      localparam logic [SW-1:0] N0 = SW'(next_len(gs, 1'b0));
      localparam logic [SW-1:0] N1 = SW'(next_len(gs, 1'b1));
      assign nxt0[gs] = N0;
      assign nxt1[gs] = N1;
    end else begin : g_dead
      assign nxt0[gs] = '0;
      assign nxt1[gs] = '0;
    end
  end

  logic [SW-1:0]    state_q, state_d;
  logic [CNT_W-1:0] cnt_d;
  logic             sat_d;
  logic             full;

  always_comb begin
    full    = (state_q == LAST) && (din == PATTERN[0]);
    dout    = en & ~rst & full;
    state_d = state_q;
    if (en) begin
      if (full && !OVERLAP) begin
        state_d = '0;
      end else begin
        state_d = din ? nxt1[state_q] : nxt0[state_q];
      end
    end
  end

  always_comb begin
    cnt_d = match_cnt;
    sat_d = cnt_sat;
    if (clr_cnt) begin
      cnt_d = '0;
      sat_d = 1'b0;
    end else if (dout) begin
      if (match_cnt != CNT_MAX) cnt_d = match_cnt + CNT_W'(1);
      if (cnt_d == CNT_MAX) sat_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= '0;
      match_cnt <= '0;
      cnt_sat   <= 1'b0;
    end else begin
      state_q   <= state_d;
      match_cnt <= cnt_d;
      cnt_sat   <= sat_d;
    end
  end

endmodule

// File: tb/tb_seq_detect_param.sv
// Bench for seq_detect_param: five configurations share one stimulus
// stream; each is compared against a sliding-window model of the stream.
module tb_seq_detect_param;

  localparam int NI = 5;

  logic clk = 1'b0;
  logic rst, en, din, clr_cnt;

  always #5 clk = ~clk;

  logic       dout_a, dout_b, dout_c, dout_d, dout_e;
  logic [7:0] cnt_a, cnt_b, cnt_c;
  logic [1:0] cnt_d;
  logic [3:0] cnt_e;
  logic       sat_a, sat_b, sat_c, sat_d, sat_e;

  seq_detect_param u_a (
    .clk(clk), .rst(rst), .en(en), .din(din), .clr_cnt(clr_cnt),
    .dout(dout_a), .match_cnt(cnt_a), .cnt_sat(sat_a)
  );

  seq_detect_param #(.OVERLAP(1'b0)) u_b (
    .clk(clk), .rst(rst), .en(en), .din(din), .clr_cnt(clr_cnt),
    .dout(dout_b), .match_cnt(cnt_b), .cnt_sat(sat_b)
  );

  seq_detect_param #(.PATTERN(16'b1101)) u_c (
    .clk(clk), .rst(rst), .en(en), .din(din), .clr_cnt(clr_cnt),
    .dout(dout_c), .match_cnt(cnt_c), .cnt_sat(sat_c)
  );

  seq_detect_param #(.CNT_W(2)) u_d (
    .clk(clk), .rst(rst), .en(en), .din(din), .clr_cnt(clr_cnt),
    .dout(dout_d), .match_cnt(cnt_d), .cnt_sat(sat_d)
  );

  seq_detect_param #(.PAT_LEN(7), .PATTERN(16'b1011011), .CNT_W(4)) u_e (
    .clk(clk), .rst(rst), .en(en), .din(din), .clr_cnt(clr_cnt),
    .dout(dout_e), .match_cnt(cnt_e), .cnt_sat(sat_e)
  );

  logic        dout_v [NI];
  logic [31:0] cnt_v  [NI];
  logic        sat_v  [NI];

  assign dout_v[0] = dout_a;
  assign dout_v[1] = dout_b;
  assign dout_v[2] = dout_c;
  assign dout_v[3] = dout_d;
  assign dout_v[4] = dout_e;
  assign cnt_v[0]  = {24'd0, cnt_a};
  assign cnt_v[1]  = {24'd0, cnt_b};
  assign cnt_v[2]  = {24'd0, cnt_c};
  assign cnt_v[3]  = {30'd0, cnt_d};
  assign cnt_v[4]  = {28'd0, cnt_e};
  assign sat_v[0]  = sat_a;
  assign sat_v[1]  = sat_b;
  assign sat_v[2]  = sat_c;
  assign sat_v[3]  = sat_d;
  assign sat_v[4]  = sat_e;

  // Reference configuration per instance.
  int plen [NI] = '{4, 4, 4, 4, 7};
  int pat  [NI] = '{'hA, 'hA, 'hD, 'hA, 'h5B};
  int ovl  [NI] = '{1, 0, 1, 1, 1};
  int cmax [NI] = '{255, 255, 255, 3, 15};

  // Model: accepted-bit history, number of bits usable toward the next
  // match, and the counter.
  int unsigned hist  [NI];
  int          avail [NI];
  int          mcnt  [NI];
  bit          msat  [NI];
  bit          pred  [NI];

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  // Match when the last PAT_LEN accepted bits (including this one) equal
  // the pattern and all of them arrived after the previous reset/match.
  function automatic bit model_dout(int i, bit e, bit d);
    int unsigned w;
    w = ((hist[i] << 1) | {31'd0, d}) & ((32'd1 << plen[i]) - 32'd1);
    return !rst && e && (avail[i] + 1 >= plen[i]) && (w == pat[i]);
  endfunction

  task automatic model_clear();
    for (int i = 0; i < NI; i++) begin
      hist[i]  = 0;
      avail[i] = 0;
      mcnt[i]  = 0;
      msat[i]  = 1'b0;
    end
  endtask

  task automatic step(input logic e, input logic d, input logic c);
    @(negedge clk);
    en      = e;
    din     = d;
    clr_cnt = c;
    #1;
    for (int i = 0; i < NI; i++) begin
      pred[i] = model_dout(i, e, d);
      check($sformatf("dout[%0d]", i), {31'd0, dout_v[i]}, {31'd0, pred[i]});
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < NI; i++) begin
      if (e) begin
        hist[i] = (hist[i] << 1) | {31'd0, d};
        if (avail[i] < 64) avail[i]++;
        if (pred[i] && ovl[i] == 0) avail[i] = 0;
      end
      if (c) begin
        mcnt[i] = 0;
        msat[i] = 1'b0;
      end else if (pred[i]) begin
        if (mcnt[i] < cmax[i]) mcnt[i]++;
        if (mcnt[i] == cmax[i]) msat[i] = 1'b1;
      end
      check($sformatf("cnt[%0d]", i), cnt_v[i], mcnt[i]);
      check($sformatf("sat[%0d]", i), {31'd0, sat_v[i]}, {31'd0, msat[i]});
    end
  endtask

  // Asynchronous reset pulse between clock edges; outputs must clear
  // before any edge arrives.
  task automatic pulse_reset();
    @(negedge clk);
    #1;
    rst     = 1'b1;
    en      = 1'b1;
    din     = 1'b0;
    clr_cnt = 1'b0;
    #1;
    model_clear();
    for (int i = 0; i < NI; i++) begin
      check($sformatf("rst_dout[%0d]", i), {31'd0, dout_v[i]}, 32'd0);
      check($sformatf("rst_cnt[%0d]", i), cnt_v[i], 32'd0);
      check($sformatf("rst_sat[%0d]", i), {31'd0, sat_v[i]}, 32'd0);
    end
    en = 1'b0;
    #1;
    rst = 1'b0;
  endtask

  task automatic run_seq(input logic [15:0] bits, input int n);
    logic [15:0] b;
    b = bits;
    for (int j = 0; j < n; j++) step(1'b1, b[n-1-j], 1'b0);
  endtask

  initial begin
    rst     = 1'b1;
    en      = 1'b0;
    din     = 1'b0;
    clr_cnt = 1'b0;
    model_clear();
    #50;
    for (int i = 0; i < NI; i++) begin
      check($sformatf("init_cnt[%0d]", i), cnt_v[i], 32'd0);
      check($sformatf("init_dout[%0d]", i), {31'd0, dout_v[i]}, 32'd0);
    end
    repeat (5) @(negedge clk);
    #1;
    rst = 1'b0;

    // Overlap vs non-overlap.
    run_seq(16'b101010010, 9);
    check("tp1_cnt_a", cnt_v[0], 32'd2);
    check("tp1_cnt_b", cnt_v[1], 32'd1);

    // Mismatch fallback for 1101.
    pulse_reset();
    run_seq(16'b11101, 5);
    check("tp3_cnt_c", cnt_v[2], 32'd1);

    // Reset mid-pattern discards the prefix.
    pulse_reset();
    run_seq(16'b101, 3);
    pulse_reset();
    step(1'b1, 1'b0, 1'b0);
    check("tp4_cnt_a0", cnt_v[0], 32'd0);
    run_seq(16'b1010, 4);
    check("tp4_cnt_a1", cnt_v[0], 32'd1);

    // Enable gating.
    pulse_reset();
    run_seq(16'b10, 2);
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    run_seq(16'b10, 2);
    check("tp5_cnt_a", cnt_v[0], 32'd1);

    // Saturation with CNT_W=2, then clear racing a match.
    pulse_reset();
    for (int j = 0; j < 12; j++) begin
      step(1'b1, (j % 2 == 0) ? 1'b1 : 1'b0, 1'b0);
      if (j == 7) begin
        check("tp6_cnt_d3", cnt_v[3], 32'd3);
        check("tp6_sat_d3", {31'd0, sat_v[3]}, 32'd1);
      end
    end
    check("tp6_cnt_d5", cnt_v[3], 32'd3);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b1);
    check("tp6_clr_cnt_d", cnt_v[3], 32'd0);
    check("tp6_clr_sat_d", {31'd0, sat_v[3]}, 32'd0);
    check("tp6_clr_cnt_a", cnt_v[0], 32'd0);

    // Random traffic.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 299) == 0) begin
        pulse_reset();
      end else begin
        step($urandom_range(0, 9) < 8, 1'($urandom_range(0, 1)),
             $urandom_range(0, 79) == 0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_detect_param.md
Name: seq_detect_param

Overview:
Parametrised Mealy serial sequence detector, the successor to the team's fixed 4-bit pattern detector. It adds a compile-time pattern of any length, overlap/non-overlap mode, an input-valid enable, and a saturating match counter with synchronous clear. It sits on a 1-bit serial data path and flags each pattern completion in the same cycle as the final bit.

Parameters:
- PAT_LEN, 4, pattern length in bits (legal 2..16).
- PATTERN, 4'b1010, pattern to detect. Bit PAT_LEN-1 is received first; bit 0 is received last.
- OVERLAP, 1, 1 = overlapping matches allowed; 0 = state restarts from empty after a match.
- CNT_W, 8, width of the match counter.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  din valid this cycle; when 0, state and counter hold.
- din  input  1  serial data bit.
- clr_cnt  input  1  synchronous clear of match_cnt and cnt_sat.
- dout  output  1  Mealy match flag (combinational).
- match_cnt  output  CNT_W  number of matches seen, saturating.
- cnt_sat  output  1  sticky flag: counter has saturated.

Behaviour:
- Interface: one clock (clk); reset rst is asynchronous and active-high.
- Reset values:
  - state = 0 (empty prefix).
  - match_cnt = 0, cnt_sat = 0.
  - dout = 0 while rst is high, regardless of din.
- State: integer S in 0..PAT_LEN-1, the length of the longest pattern prefix matched so far. Encoded in clog2(PAT_LEN) bits.
- Expected bit in state S: PATTERN[PAT_LEN-1-S].
- dout = en & (S == PAT_LEN-1) & (din == PATTERN[0]).
  - Purely combinational; zero latency.
  - Asserts during the cycle the last pattern bit is presented; no register stage.
- Next state, on clk rising edge with en=1:
  - Bit matches and S < PAT_LEN-1: S <= S+1.
  - Full match (dout=1), OVERLAP=1: S <= length of the longest proper prefix of PATTERN that is also a suffix of PATTERN (KMP failure value).
  - Full match, OVERLAP=0: S <= 0.
  - Mismatch: S <= length of the longest prefix of PATTERN that is a suffix of (matched prefix followed by din). This can be nonzero, e.g. pattern 1101 in state 2 receiving 1 stays in state 2.
- Transition table:
  - Computed at elaboration from PATTERN via generate/function.
  - No run-time pattern storage.
- en=0: S holds and dout=0.
- Counter:
  - On a clock edge with dout=1 and match_cnt < 2^CNT_W-1: match_cnt increments.
  - On reaching all-ones: match_cnt holds and cnt_sat sets. cnt_sat stays set until clr_cnt or rst.
- clr_cnt priority:
  - clr_cnt beats a simultaneous increment: match_cnt = 0 and cnt_sat = 0 after the edge; that match is not counted.
  - clr_cnt does not affect S.
- Reset mid-pattern: S returns to 0 immediately (asynchronous). A partial prefix is never resumed after rst deasserts.
- PATTERN bits above PAT_LEN-1 are ignored. PAT_LEN outside 2..16 must fail elaboration.

Test Plan:
- Defaults, rst high 100 ns, then din = 1,0,1,0,1,0,0,1,0 with en=1, one bit per cycle -> dout=1 on bits 4 and 6 only; match_cnt = 2 at end.
- OVERLAP=0, din = 1,0,1,0,1,0 -> dout=1 on bit 4 only; bit 6 gives no match; match_cnt = 1.
- PATTERN=4'b1101, din = 1,1,1,0,1 -> dout=1 on bit 5 (mismatch fallback keeps state 2); match_cnt = 1.
- Defaults, din = 1,0,1 then rst pulse mid-cycle, then din=0 -> dout stays 0; match_cnt = 0. Then 1,0,1,0 -> one match.
- en gating: send 1,0 with en=1, then 3 cycles en=0 with din toggling, then 1,0 with en=1 -> single dout pulse on the final bit; no pulses while en=0.
- CNT_W=2, five overlapping matches of 1010 -> match_cnt reads 1,2,3,3,3; cnt_sat=1 after the 3rd match. clr_cnt asserted in the same cycle as a match -> match_cnt = 0, cnt_sat = 0.
